clock_time_sequencer: RTL
=========================

Name: clock_time_sequencer

Overview:
- Owns the seconds/minutes/hours counting chain for the analog clock.
- Sequences carries from a 1 Hz tick into second, minute and hour advances.
- Arbitrates between the free-running tick and user set buttons through a RUN/SET mode FSM.
- Drives the hand-position datapath with counts, one-cycle step pulses and a half-hour phase toggle.

Parameters:
- TICK_DIV, 1: tickIn pulses per second advance; legal range 1..65535.
- SET_HOLD_SECONDS, 0: when 1, seconds are held at 0 while in any SET state; when 0, seconds keep counting in SET states.

Ports:
- clock, input, 1: system clock; all state updates on the rising edge.
- resetN, input, 1: asynchronous, active-low reset.
- tickIn, input, 1: one-cycle 1 Hz enable pulse, synchronous to clock.
- modeBtn, input, 1: one-cycle pulse, already debounced and synchronized; cycles the mode.
- incBtn, input, 1: one-cycle pulse, already debounced and synchronized; increments the selected field.
- seconds, output, 6: current seconds, 0..59.
- minutes, output, 6: current minutes, 0..59.
- hours, output, 4: current hours, 0..11; width 5 with the option below.
- secondStep, output, 1: one-cycle pulse when seconds changes.
- minuteStep, output, 1: one-cycle pulse when minutes changes.
- hourStep, output, 1: one-cycle pulse when hours changes.
- halfHourPhase, output, 1: level that inverts each time minutes wraps to 0 or reaches 30.
- mode, output, 2: current mode; 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN.

Behaviour:
- Reset (resetN low, asynchronous): all counts = 0, all step pulses = 0, halfHourPhase = 0, mode = RUN, prescaler = 0. Outputs stay in this state until the first rising edge after resetN goes high.
- Reset mid-operation aborts any pending carry; no step pulse is emitted for the aborted carry.
- All outputs are registered. A count change and its step pulse appear together, one clock after the triggering input was sampled high.
- Prescaler: counts tickIn pulses. When the count reaches TICK_DIV-1 and tickIn is high, it returns to 0 and a second advance occurs.
- Carry chain, evaluated in a single cycle:
  - second 59 -> 0 carries to minutes.
  - minute 59 -> 0 carries to hours.
  - hour 11 -> 0 wraps.
  - Example: 11:59:59 -> 0:00:00 in one cycle, with secondStep, minuteStep and hourStep all asserted.
- halfHourPhase inverts on every minutes transition into 30 or into 0, whether caused by a carry or by incBtn.
- FSM transitions, on a modeBtn pulse: RUN -> SET_HOUR -> SET_MIN -> RUN.
- RUN: incBtn is ignored.
- SET_HOUR: incBtn advances hours by 1 with wrap; asserts hourStep only; no carry into other fields.
- SET_MIN: incBtn advances minutes by 1 with wrap; asserts minuteStep only; never carries into hours.
- Arbitration in SET states:
  - Tick-driven minute and hour carries are suppressed.
  - If SET_HOLD_SECONDS = 1: seconds are cleared to 0 on SET entry (secondStep asserted if the value changed) and frozen; the prescaler is held at 0.
  - If SET_HOLD_SECONDS = 0: seconds still count and wrap at 59 without carrying.
- Simultaneous events:
  - modeBtn together with incBtn: the mode change wins; incBtn is dropped.
  - tickIn together with incBtn in SET: both apply, under the rules above.
  - modeBtn together with a RUN carry: the carry completes in this cycle, and the mode changes in the same cycle.
- mode encoding 3 is unreachable; if decoded, the FSM returns to RUN on the next edge.

Optional Feature:
- Macro: TWENTY_FOUR_HOUR_EN.
- Defined: hours is 5 bits and counts 0..23, wrapping 23 -> 0; SET_HOUR incBtn wraps 23 -> 0.
- Undefined: hours is 4 bits and counts 0..11, wrapping 11 -> 0.

Decomposition:
- Shared package clock_pkg:
  - Mode enum: RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2.
  - Constants SEC_MAX = 59, MIN_MAX = 59, MIN_HALF = 30, HOUR_MAX (11, or 23 under the macro), HOUR_W.
- Sub-module mod_n_counter: parameterized width and MAX, with enable, wrap and carry-out. Instantiated for seconds, minutes and hours.
- The FSM, arbitration and prescaler live in the top module.

Test Plan:
- Reset: hold resetN low while pulsing tickIn -> all outputs 0; release, then 1 tick -> seconds = 1, secondStep high for exactly one cycle.
- Full wrap: preload 11:59:59 via the SET modes plus ticks, then 1 tick -> 0:00:00, all three step pulses high in the same cycle, halfHourPhase inverts.
- Half-hour: run from minute 29 second 59, 1 tick -> minutes = 30, halfHourPhase inverts, hours unchanged.
- SET flow: modeBtn, then incBtn x3 -> hours = 3, hourStep x3, minutes unchanged; modeBtn, then incBtn x61 -> minutes = 1, hours still 3; modeBtn -> mode = RUN.
- Collisions: modeBtn with incBtn in SET_HOUR -> mode = SET_MIN, hours unchanged. With SET_HOLD_SECONDS = 1, ticks in SET -> seconds stay 0.
- Async reset mid-carry: assert resetN low coincident with a tick at 0:59:59 -> immediate all-zero outputs, no step pulse after release. Under TWENTY_FOUR_HOUR_EN: 23:59:59 plus 1 tick -> 0:00:00.

Source files
------------

// File: rtl/clock_time_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module   : clock_pkg
// Brief    : Shared mode encoding and count limits for the clock sequencer.
//            Optional macro TWENTY_FOUR_HOUR_EN selects a 0..23 hour range.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_e;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] MIN_HALF = 6'd30;

`ifdef TWENTY_FOUR_HOUR_EN
  localparam int              HOUR_W   = 5;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
`else
  localparam int              HOUR_W   = 4;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 4'd11;
`endif

  // True when incrementing from cur lands minutes on 0 or on the half hour.
  function automatic logic halfHourEdge(input logic [5:0] cur);
    return (cur == MIN_HALF - 6'd1) || (cur == MIN_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_time_sequencer_counter.sv
//------------------------------------------------------------------------------
// Module   : mod_n_counter
// Brief    : Modulo-(MAX+1) up counter with synchronous clear and carry-out.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mod_n_counter #(
  parameter int               WIDTH = 6,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             carryOut
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= (r_count == MAX) ? '0 : r_count + 1'b1;
    end
  end

  // Carry is independent of clear so a wrap coinciding with a clear still propagates.
  assign carryOut = inc && (r_count == MAX);
  assign count    = r_count;

endmodule

`default_nettype wire

// File: rtl/clock_time_sequencer.sv
//------------------------------------------------------------------------------
// Module   : clock_time_sequencer
// Brief    : Seconds/minutes/hours chain with RUN/SET mode FSM and prescaler.
//            Optional macro TWENTY_FOUR_HOUR_EN widens hours to 0..23.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clock_time_sequencer
  import clock_pkg::*;
#(
  parameter int TICK_DIV         = 1,
  parameter int SET_HOLD_SECONDS = 0
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              tickIn,
  input  logic              modeBtn,
  input  logic              incBtn,
  output logic [5:0]        seconds,
  output logic [5:0]        minutes,
  output logic [HOUR_W-1:0] hours,
  output logic              secondStep,
  output logic              minuteStep,
  output logic              hourStep,
  output logic              halfHourPhase,
  output logic [1:0]        mode
);

  localparam logic [1:0]  c_RUN        = RUN;
  localparam logic [1:0]  c_SET_HOUR   = SET_HOUR;
  localparam logic [1:0]  c_SET_MIN    = SET_MIN;
  localparam logic        c_HOLD       = (SET_HOLD_SECONDS != 0);
  localparam logic [15:0] c_PRESC_LAST = 16'(TICK_DIV - 1);

  logic [1:0]  r_mode;
  logic [15:0] r_presc;
  logic        r_secondStep;
  logic        r_minuteStep;
  logic        r_hourStep;
  logic        r_phase;

  logic w_inRun;
  logic w_inSet;
  logic w_hold;
  logic w_incOk;
  logic w_secAdv;
  logic w_secClr;
  logic w_secCarry;
  logic w_minInc;
  logic w_minCarry;
  logic w_hourInc;
  logic w_hourCarry;

  assign w_inRun  = (r_mode == c_RUN);
  assign w_inSet  = (r_mode == c_SET_HOUR) || (r_mode == c_SET_MIN);
  assign w_hold   = c_HOLD && w_inSet;
  assign w_incOk  = incBtn && !modeBtn;
  assign w_secAdv = tickIn && !w_hold && (r_presc == c_PRESC_LAST);
  // With hold enabled, seconds are zeroed on the RUN->SET edge and kept there.
  assign w_secClr = c_HOLD && (w_inSet || (w_inRun && modeBtn));

  assign w_minInc  = (w_inRun && w_secCarry) || ((r_mode == c_SET_MIN) && w_incOk);
  assign w_hourInc = (w_inRun && w_minCarry) || ((r_mode == c_SET_HOUR) && w_incOk);

  mod_n_counter #(.WIDTH(6), .MAX(SEC_MAX)) u_sec (
    .clock    (clock),
    .resetN   (resetN),
    .inc      (w_secAdv),
    .clear    (w_secClr),
    .count    (seconds),
    .carryOut (w_secCarry)
  );

  mod_n_counter #(.WIDTH(6), .MAX(MIN_MAX)) u_min (
    .clock    (clock),
    .resetN   (resetN),
    .inc      (w_minInc),
    .clear    (1'b0),
    .count    (minutes),
    .carryOut (w_minCarry)
  );

  mod_n_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clock    (clock),
    .resetN   (resetN),
    .inc      (w_hourInc),
    .clear    (1'b0),
    .count    (hours),
    .carryOut (w_hourCarry)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_presc <= '0;
    end else if (w_hold) begin
      r_presc <= '0;
    end else if (tickIn) begin
      r_presc <= (r_presc == c_PRESC_LAST) ? 16'd0 : r_presc + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_mode <= c_RUN;
    end else begin
      case (r_mode)
        c_RUN:      if (modeBtn) r_mode <= c_SET_HOUR;
        c_SET_HOUR: if (modeBtn) r_mode <= c_SET_MIN;
        c_SET_MIN:  if (modeBtn) r_mode <= c_RUN;
        default:    r_mode <= c_RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_secondStep <= 1'b0;
      r_minuteStep <= 1'b0;
      r_hourStep   <= 1'b0;
      r_phase      <= 1'b0;
    end else begin
      r_secondStep <= w_secClr ? (seconds != 6'd0) : w_secAdv;
      r_minuteStep <= w_minInc;
      r_hourStep   <= w_hourInc;
      if (w_minInc && halfHourEdge(minutes)) begin
        r_phase <= ~r_phase;
      end
    end
  end

  assign secondStep    = r_secondStep;
  assign minuteStep    = r_minuteStep;
  assign hourStep      = r_hourStep;
  assign halfHourPhase = r_phase;
  assign mode          = r_mode;

endmodule

`default_nettype wire
